// File: rtl/fetch_seq_if.sv
// fetch_seq_if: instruction-memory, decode and execute handshake bundle of the fetch sequencer.
// master = sequencer side, slave = memory/decode/execute side.
interface fetch_seq_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        commit_i;
  logic [1:0]  npc_op_i;
  logic [31:0] imm_i;
  logic        br_taken_i;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;
  logic        misalign_o;
  logic        timeout_o;

  modport master (
    output imem_req_o, imem_addr_o, inst_o, inst_valid_o, pc_o, pc4_o, misalign_o, timeout_o,
    input  imem_ack_i, imem_rdata_i, inst_ready_i, commit_i, npc_op_i, imm_i, br_taken_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, inst_o, inst_valid_o, pc_o, pc4_o, misalign_o, timeout_o,
    output imem_ack_i, imem_rdata_i, inst_ready_i, commit_i, npc_op_i, imm_i, br_taken_i
  );
endinterface

// File: rtl/fetch_seq.sv
// fetch_seq: multi-cycle fetch / next-PC sequencer that owns the architectural PC.
// Define FETCH_TIMEOUT_EN to build in the fetch watchdog (limit set by TIMEOUT).
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input logic         clk,
  input logic         reset,
  fetch_seq_if.master bus
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    ISSUE = 3'd2,
    EXEC  = 3'd3,
    ERR   = 3'd4
  } state_e;

  state_e      state_r;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic        req_r;
  logic        inst_valid_r;
  logic        misalign_r;
  logic        timeout_r;
  logic [31:0] pc4_s;
  logic [31:0] target_s;
  logic        target_misaligned_s;

  if (TIMEOUT < 32'd2 || TIMEOUT > 32'd255) begin : g_timeout_range
    $error("fetch_seq: TIMEOUT must lie within 2..255");
  end

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 32'd1);
  logic [7:0] wdog_r;
`endif

  assign pc4_s = pc_r + 32'd4;

  // Next-PC selection from the committed npc_op; JALR arrives as a full rs1+imm target.
  always_comb begin
    target_s = pc4_s;
    case (bus.npc_op_i)
      2'b00: target_s = pc4_s;
      2'b01: begin
        if (bus.br_taken_i) begin
          target_s = pc_r + bus.imm_i;
        end else begin
          target_s = pc4_s;
        end
      end
      2'b10:   target_s = pc_r + bus.imm_i;
      2'b11:   target_s = bus.imm_i & 32'hFFFF_FFFE;
      default: target_s = pc4_s;
    endcase
    target_misaligned_s = (target_s[1:0] != 2'b00);
  end

  // Sequencer FSM together with the PC and every registered output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= BOOT;
      pc_r         <= RESET_PC;
      inst_r       <= 32'h0000_0000;
      inst_valid_r <= 1'b0;
      req_r        <= 1'b0;
      misalign_r   <= 1'b0;
      timeout_r    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wdog_r       <= 8'd0;
`endif
    end else begin
      case (state_r)
        BOOT: begin
          state_r <= REQ;
          req_r   <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
          wdog_r  <= 8'd0;
`endif
        end
        REQ: begin
          if (bus.imem_ack_i) begin
            inst_r       <= bus.imem_rdata_i;
            inst_valid_r <= 1'b1;
            req_r        <= 1'b0;
            state_r      <= ISSUE;
          end else begin
`ifdef FETCH_TIMEOUT_EN
            // An ack on the last allowed cycle takes the branch above, so it wins.
            if (wdog_r == WDOG_LAST) begin
              timeout_r <= 1'b1;
              req_r     <= 1'b0;
              state_r   <= ERR;
            end else begin
              wdog_r <= wdog_r + 8'd1;
            end
`endif
          end
        end
        ISSUE: begin
          if (bus.inst_ready_i) begin
            inst_valid_r <= 1'b0;
            state_r      <= EXEC;
          end else begin
            inst_valid_r <= 1'b1;
          end
        end
        EXEC: begin
          if (bus.commit_i) begin
            if (target_misaligned_s) begin
              misalign_r <= 1'b1;
              state_r    <= ERR;
            end else begin
              pc_r    <= target_s;
              req_r   <= 1'b1;
              state_r <= REQ;
`ifdef FETCH_TIMEOUT_EN
              wdog_r  <= 8'd0;
`endif
            end
          end else begin
            state_r <= EXEC;
          end
        end
        ERR: begin
          req_r        <= 1'b0;
          inst_valid_r <= 1'b0;
        end
        default: begin
          req_r        <= 1'b0;
          inst_valid_r <= 1'b0;
          state_r      <= ERR;
        end
      endcase
    end
  end

  assign bus.imem_req_o   = req_r;
  assign bus.imem_addr_o  = pc_r;
  assign bus.inst_o       = inst_r;
  assign bus.inst_valid_o = inst_valid_r;
  assign bus.pc_o         = pc_r;
  assign bus.pc4_o        = pc4_s;
  assign bus.misalign_o   = misalign_r;
  assign bus.timeout_o    = timeout_r;

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: randomized bench for fetch_seq with a next-PC reference model and scoreboard queues.
module tb_fetch_seq;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;

  fetch_seq_if bus();

  fetch_seq #(.RESET_PC(RESET_PC), .TIMEOUT(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] imm;
    logic        taken;
  } op_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];
  int          exp_len_q[$];
  int          rise_cyc_q[$];
  op_t         dir_q[$];
  int          ack_fix = 0, ready_fix = 0, commit_fix = 0;
  bit          mem_hold = 1'b0;
  logic [31:0] model_pc;
  bit          exp_err = 1'b0;
  logic [31:0] err_pc;
  int          n_commits = 0;
  bit          exec_active = 1'b0;
  int          cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event occurred, expected it not to", name);
  endtask

  function automatic op_t mk(input logic [1:0] op, input logic [31:0] imm, input logic taken);
    op_t o;
    o.op = op; o.imm = imm; o.taken = taken;
    return o;
  endfunction

  // Architectural next-PC rule for one committed instruction.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input op_t o);
    case (o.op)
      2'd0:    return pc + 32'd4;
      2'd1:    return o.taken ? pc + o.imm : pc + 32'd4;
      2'd2:    return pc + o.imm;
      default: return o.imm & 32'hFFFF_FFFE;
    endcase
  endfunction

  function automatic int pick(input int fix);
    return (fix >= 0) ? fix : int'($urandom_range(0, 3));
  endfunction

  // Environment: memory, decode and execute agents; drives inputs at negedge.
  initial begin : env
    bit  in_req = 1'b0, in_iss = 1'b0;
    int  wl = 0, rw = 0, cw = 0;
    op_t o;
    logic [31:0] tgt;
    bus.imem_ack_i = 1'b0; bus.imem_rdata_i = 32'h0; bus.inst_ready_i = 1'b0;
    bus.commit_i = 1'b0; bus.npc_op_i = 2'b00; bus.imm_i = 32'h0; bus.br_taken_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_req = 1'b0; in_iss = 1'b0; exec_active = 1'b0;
        bus.imem_ack_i = 1'b0; bus.inst_ready_i = 1'b0; bus.commit_i = 1'b0;
      end else begin
        if (exec_active) begin
          if (cw == 0) begin
            if (dir_q.size() > 0) o = dir_q.pop_front();
            else begin
              o.op    = 2'($urandom_range(0, 3));
              o.imm   = $urandom & 32'hFFFF_FFFC;
              if (o.op == 2'd3) o.imm = o.imm | ($urandom & 32'h1);
              o.taken = 1'($urandom_range(0, 1));
            end
            bus.commit_i = 1'b1; bus.npc_op_i = o.op; bus.imm_i = o.imm; bus.br_taken_i = o.taken;
            tgt = model_next(model_pc, o);
            if (tgt[1:0] != 2'b00) begin
              exp_err = 1'b1;
              err_pc  = model_pc;
            end else begin
              model_pc = tgt;
              exp_addr_q.push_back(tgt);
            end
            n_commits++;
            exec_active = 1'b0;
          end else begin
            bus.commit_i = 1'b0;
            cw--;
          end
        end else begin
          bus.commit_i   = 1'($urandom_range(0, 1));
          bus.npc_op_i   = 2'($urandom_range(0, 3));
          bus.imm_i      = $urandom;
          bus.br_taken_i = 1'($urandom_range(0, 1));
        end
        if (bus.inst_valid_o) begin
          if (!in_iss) begin in_iss = 1'b1; rw = pick(ready_fix); end
          if (rw == 0) begin
            bus.inst_ready_i = 1'b1; in_iss = 1'b0; exec_active = 1'b1; cw = pick(commit_fix);
          end else begin
            bus.inst_ready_i = 1'b0; rw--;
          end
        end else begin
          bus.inst_ready_i = 1'($urandom_range(0, 1));
        end
        if (bus.imem_req_o) begin
          if (mem_hold) begin
            bus.imem_ack_i = 1'b0;
          end else begin
            if (!in_req) begin in_req = 1'b1; wl = pick(ack_fix); exp_len_q.push_back(wl + 1); end
            if (wl == 0) begin
              bus.imem_ack_i = 1'b1; bus.imem_rdata_i = $urandom;
              exp_inst_q.push_back(bus.imem_rdata_i); in_req = 1'b0;
            end else begin
              bus.imem_ack_i = 1'b0; wl--;
            end
          end
        end else begin
          in_req = 1'b0;
          bus.imem_ack_i   = 1'($urandom_range(0, 1));
          bus.imem_rdata_i = $urandom;
        end
      end
    end
  end

  // Monitor: pops expected values whenever the DUT presents a request or an instruction.
  initial begin : mon
    bit          pr = 1'b0, pv = 1'b0;
    logic [31:0] pa = 32'h0, pi = 32'h0, cur_pc = RESET_PC;
    int          rl = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        pr = 1'b0; pv = 1'b0; rl = 0; cur_pc = RESET_PC;
      end else begin
        if (bus.imem_req_o) begin
          if (!pr) begin
            rise_cyc_q.push_back(cyc);
            if (exp_addr_q.size() > 0) begin
              cur_pc = exp_addr_q.pop_front();
              check("fetch_addr", bus.imem_addr_o, cur_pc);
            end else fail_now("unexpected_request");
            rl = 0;
          end else check("addr_stable", bus.imem_addr_o, pa);
          rl++;
        end else if (pr) begin
          if (exp_len_q.size() > 0) check("req_cycles", rl, exp_len_q.pop_front());
          else if (!mem_hold) fail_now("unplanned_req_drop");
        end
        if (bus.inst_valid_o) begin
          if (!pv) begin
            if (exp_inst_q.size() > 0) check("inst_word", bus.inst_o, exp_inst_q.pop_front());
            else fail_now("unexpected_valid");
          end else check("inst_stable", bus.inst_o, pi);
        end
        check("pc", bus.pc_o, cur_pc);
        check("pc4", bus.pc4_o, cur_pc + 32'd4);
        pr = bus.imem_req_o; pa = bus.imem_addr_o;
        pv = bus.inst_valid_o; pi = bus.inst_o;
      end
    end
  end

  task automatic start_reset();
    reset = 1'b0;
    exp_addr_q.delete(); exp_inst_q.delete(); exp_len_q.delete(); rise_cyc_q.delete(); dir_q.delete();
    exec_active = 1'b0; exp_err = 1'b0;
    model_pc = RESET_PC;
    exp_addr_q.push_back(RESET_PC);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    start_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic wait_commits(input int n);
    for (int i = 0; i < 3000; i++) begin
      if (n_commits >= n) break;
      @(posedge clk);
    end
    if (n_commits < n) begin
      n_tests++; n_fail++;
      $display("FAIL commit_wait: got %0d commits expected %0d", n_commits, n);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"}, 32'(bus.imem_req_o), 32'd0);
    check({tag, "_addr"}, bus.imem_addr_o, RESET_PC);
    check({tag, "_inst"}, bus.inst_o, 32'h0);
    check({tag, "_valid"}, 32'(bus.inst_valid_o), 32'd0);
    check({tag, "_pc"}, bus.pc_o, RESET_PC);
    check({tag, "_pc4"}, bus.pc4_o, RESET_PC + 32'd4);
    check({tag, "_misalign"}, 32'(bus.misalign_o), 32'd0);
    check({tag, "_timeout"}, 32'(bus.timeout_o), 32'd0);
  endtask

  initial begin : main
    int c0;
    int req_cnt;
    reset = 1'b1;
    #1;
    start_reset();
    repeat (2) @(posedge clk);
    #2 check_reset_vals("reset");
    dir_q.push_back(mk(2'd0, 32'h0, 1'b0));
    dir_q.push_back(mk(2'd0, 32'h0, 1'b0));
    dir_q.push_back(mk(2'd0, 32'h0, 1'b0));
    dir_q.push_back(mk(2'd0, 32'h0, 1'b0));
    dir_q.push_back(mk(2'd1, 32'hFFFF_FFF8, 1'b1));
    dir_q.push_back(mk(2'd0, 32'h0, 1'b0));
    dir_q.push_back(mk(2'd0, 32'h0, 1'b0));
    dir_q.push_back(mk(2'd1, 32'hFFFF_FFF8, 1'b0));
    dir_q.push_back(mk(2'd0, 32'h0, 1'b0));
    dir_q.push_back(mk(2'd0, 32'h0, 1'b0));
    dir_q.push_back(mk(2'd0, 32'h0, 1'b0));
    dir_q.push_back(mk(2'd2, 32'h0000_0100, 1'b0));
    dir_q.push_back(mk(2'd3, 32'hFFFF_FFFD, 1'b0));
    dir_q.push_back(mk(2'd0, 32'h0, 1'b0));
    ack_fix = 0; ready_fix = 0; commit_fix = 0;
    reset = 1'b1;
    wait_commits(5);
    for (int i = 1; i < 4; i++) begin
      if (rise_cyc_q.size() > i) check("period", 32'(rise_cyc_q[i] - rise_cyc_q[i-1]), 32'd3);
      else fail_now("period_missing_request");
    end
    wait_commits(14);
    ack_fix = 5; ready_fix = 2; commit_fix = 1;
    wait_commits(17);
    ack_fix = -1; ready_fix = -1; commit_fix = -1;
    wait_commits(77);
    dir_q.push_back(mk(2'd3, 32'h0000_0203, 1'b0));
    for (int i = 0; i < 200 && !exp_err; i++) @(posedge clk);
    check("err_expected", 32'(exp_err), 32'd1);
    repeat (20) @(posedge clk);
    #2;
    check("err_misalign", 32'(bus.misalign_o), 32'd1);
    check("err_pc", bus.pc_o, err_pc);
    check("err_req", 32'(bus.imem_req_o), 32'd0);
    check("err_valid", 32'(bus.inst_valid_o), 32'd0);
    check("err_timeout", 32'(bus.timeout_o), 32'd0);

    pulse_reset();
    ack_fix = 0; ready_fix = 0; commit_fix = 3;
    for (int i = 0; i < 200 && !exec_active; i++) begin
      @(posedge clk); #2;
    end
    check("exec_reached", 32'(exec_active), 32'd1);
    @(posedge clk); #2;
    start_reset();
    #1 check_reset_vals("exec_reset");
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    ack_fix = -1; ready_fix = -1; commit_fix = -1;
    c0 = n_commits;
    wait_commits(c0 + 4);

`ifdef FETCH_TIMEOUT_EN
    @(posedge clk); #2;
    start_reset();
    mem_hold = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    req_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (bus.timeout_o) break;
      if (bus.imem_req_o) req_cnt++;
    end
    check("timeout_req_cycles", 32'(req_cnt), 32'd16);
    check("timeout_flag", 32'(bus.timeout_o), 32'd1);
    check("timeout_req_drop", 32'(bus.imem_req_o), 32'd0);
    mem_hold = 1'b0;
    pulse_reset();
    ack_fix = 15;
    c0 = n_commits;
    wait_commits(c0 + 2);
    check("late_ack_no_timeout", 32'(bus.timeout_o), 32'd0);
    ack_fix = -1;
`else
    @(posedge clk); #2;
    start_reset();
    mem_hold = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    req_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #2;
      if (bus.imem_req_o) req_cnt++;
    end
    check("no_timeout_flag", 32'(bus.timeout_o), 32'd0);
    check("no_timeout_req_cycles", 32'(req_cnt), 32'd1000);
    check("no_timeout_addr", bus.imem_addr_o, RESET_PC);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
